att_serial_writer: RTL
======================

# att_serial_writer

Serial write engine for the step attenuator, sitting directly downstream of the AXI attenuator register block in the CLK_ATT domain. Accepts one attenuation word per valid/ready handshake and shifts it out LSB-first on SI/SCLK. It then pulses LE and holds BUSY through a programmable settle interval, ending each write with a one-cycle DONE. Replaces gated-clock serialisation with a fully registered SCLK and an explicit FSM.

## Interface
- DATA_WIDTH, 16, attenuation word width; bits shifted per write.
- CLK_DIV, 1, SCLK half-period in CLK_ATT cycles; must be ≥1.
- SETTLE_CYCLES, 390, CLK_ATT cycles BUSY stays high after LE; 0 allowed.

Ports:
- CLK_ATT  in  1  block clock; all logic on rising edge.
- RESET_ATT  in  1  reset, asynchronous, active-high.
- S_DATA  in  DATA_WIDTH  word to write; sampled only at accept.
- S_VALID  in  1  word available.
- S_READY  out  1  high only in IDLE.
- SI  out  1  serial data to attenuator.
- SCLK  out  1  serial clock; device samples on rising edge.
- LE  out  1  latch enable pulse.
- BUSY  out  1  high from accept until DONE cycle.
- DONE  out  1  one-cycle pulse, write complete.

## Operation
- Accept: S_VALID && S_READY at a rising edge; S_DATA copied into shift register; state → SHIFT next cycle.
- FSM states: IDLE → SHIFT → LATCH → SETTLE → IDLE. With SETTLE_CYCLES=0, LATCH → IDLE.
- SHIFT: DATA_WIDTH bits, index 0 first. Each bit = 2·CLK_DIV cycles. SI takes the bit value with SCLK low for CLK_DIV cycles, then SCLK high for CLK_DIV cycles. Bit counter 0..DATA_WIDTH-1; leaves SHIFT after the last SCLK high phase.
- LATCH: SCLK low, SI low, LE high for exactly 2·CLK_DIV cycles.
- SETTLE: counter of width $clog2(SETTLE_CYCLES+1) counts SETTLE_CYCLES cycles; all serial outputs low.
- Return to IDLE: DONE=1 for that first IDLE cycle; S_READY=1 in the same cycle. Back-to-back accept is legal in the DONE cycle.
- S_VALID while not ready is ignored. The source must hold data per valid/ready rules. S_DATA changes after accept have no effect.
- SI, SCLK and LE are all registered outputs, glitch-free. SI and SCLK are low whenever not in SHIFT.

## Timing
- Reset values: S_READY=0 while RESET_ATT high, 1 in first cycle after release; SI=SCLK=LE=BUSY=DONE=0; shift register, counters and last-word store cleared; last-word valid flag cleared.
- Accept at edge t0: first SI bit valid from t0+1. First SCLK rise at t0+1+CLK_DIV.
- CLK_DIV=1, DATA_WIDTH=16: SHIFT occupies t0+1..t0+32. LE is high t0+33..t0+34. SETTLE occupies t0+35..t0+34+SETTLE_CYCLES. DONE and S_READY are high at t0+35+SETTLE_CYCLES.
- BUSY rises the cycle after accept and falls in the DONE cycle.
- RESET_ATT mid-operation: all outputs forced to reset values immediately (asynchronously); the in-flight write is abandoned, with no LE and no DONE.

## Configuration
- ATT_SKIP_UNCHANGED_EN defined: the block keeps the last word that completed LATCH plus a valid flag.
  - An accepted word equal to a valid last word skips SHIFT, LATCH and SETTLE.
  - BUSY stays 0 and DONE pulses at t0+1, with S_READY high at t0+1.
  - The flag is cleared by reset and set when LATCH completes.
- Not defined: every accepted word is fully shifted, latched and settled; no comparison logic.

## Test plan
- Reset release, SETTLE_CYCLES=4: accept 16'hA5C3 → SI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on successive SCLK rises; LE high t0+33..34; DONE at t0+39.
- CLK_DIV=3: accept 16'h0001 → SCLK period 6 cycles; SI=1 only during the first bit; LE width 6 cycles.
- Back-to-back: S_VALID held high with 16'h1234 then 16'h4321 → second accept in the first write's DONE cycle; no idle gap; two LE pulses.
- RESET_ATT asserted at t0+10 of a write → SI/SCLK/LE/BUSY go 0 without a clock edge; no DONE. After release, a new write of 16'hFFFF completes normally.
- ATT_SKIP_UNCHANGED_EN: write 16'h0042 twice → first write produces 16 SCLK rises and LE; second has no SCLK/LE, DONE at t0+1. After reset, 16'h0042 is shifted again.
- SETTLE_CYCLES=0: accept 16'h8000 → DONE at t0+35, directly after the LE high phase.

Source files
------------

// File: rtl/att_serial_writer_if.sv
// att_serial_writer_if: word handshake between the attenuator register
// block (master) and the serial write engine (slave).
interface att_serial_writer_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] S_DATA;
   logic                  S_VALID;
   logic                  S_READY;

   modport master (output S_DATA, output S_VALID, input S_READY);
   modport slave  (input S_DATA, input S_VALID, output S_READY);
endinterface

// File: rtl/att_serial_writer.sv
// att_serial_writer: step attenuator serial write engine (CLK_ATT domain).
// Optional ATT_SKIP_UNCHANGED_EN skips writes equal to the last latched word.
module att_serial_writer #(
   parameter int DATA_WIDTH    = 16,
   parameter int CLK_DIV       = 1,
   parameter int SETTLE_CYCLES = 390
) (
   input  logic                CLK_ATT,
   input  logic                RESET_ATT,
   att_serial_writer_if.slave  s_if,
   output logic                SI,
   output logic                SCLK,
   output logic                LE,
   output logic                BUSY,
   output logic                DONE
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int SET_L = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

   localparam logic [DIV_W-1:0] HALF_END  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] LATCH_END = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SET_L);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH,
      ST_SETTLE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DIV_W-1:0]      r_div;
   logic                  r_phase;
   logic [BIT_W-1:0]      r_bit;
   logic [SET_W-1:0]      r_settle;
   logic                  r_si;
   logic                  r_sclk;
   logic                  r_le;
   logic                  r_busy;
   logic                  r_done;

   logic w_ready;
   logic w_accept;
   logic w_skip;
   logic w_half_end;
   logic w_bit_last;
   logic w_latch_end;
   logic w_settle_end;
   logic w_si_nxt;
   logic w_sclk_nxt;
   logic w_le_nxt;
   logic w_busy_nxt;
   logic w_done_nxt;

   // Ready drops with reset so nothing is accepted while held in reset.
   assign w_ready      = (r_state == ST_IDLE) & ~RESET_ATT;
   assign s_if.S_READY = w_ready;
   assign w_accept     = s_if.S_VALID & w_ready;
   assign w_half_end   = (r_div == HALF_END);
   assign w_bit_last   = (r_bit == BIT_LAST);
   assign w_latch_end  = (r_div == LATCH_END);
   assign w_settle_end = (r_settle == SET_LAST);

   assign SI   = r_si;
   assign SCLK = r_sclk;
   assign LE   = r_le;
   assign BUSY = r_busy;
   assign DONE = r_done;

`ifdef ATT_SKIP_UNCHANGED_EN
   logic [DATA_WIDTH-1:0] r_word;
   logic [DATA_WIDTH-1:0] r_last;
   logic                  r_last_vld;

   assign w_skip = r_last_vld && (s_if.S_DATA == r_last);

   // Keep the accepted word and remember it once it has been latched.
   always_ff @(posedge CLK_ATT or posedge RESET_ATT) begin
      if (RESET_ATT) begin
         r_word     <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else begin
         if (w_accept)
            r_word <= s_if.S_DATA;
         if (r_state == ST_LATCH && w_latch_end) begin
            r_last     <= r_word;
            r_last_vld <= 1'b1;
         end
      end
   end
`else
   assign w_skip = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK_ATT or posedge RESET_ATT) begin
      if (RESET_ATT)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:
            if (w_accept && !w_skip)
               w_state_nxt = ST_SHIFT;
         ST_SHIFT:
            if (w_half_end && r_phase && w_bit_last)
               w_state_nxt = ST_LATCH;
         ST_LATCH:
            if (w_latch_end)
               w_state_nxt = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
         ST_SETTLE:
            if (w_settle_end)
               w_state_nxt = ST_IDLE;
         default:
            w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the next state.
   always_comb begin
      w_si_nxt   = 1'b0;
      w_sclk_nxt = 1'b0;
      if (w_state_nxt == ST_SHIFT) begin
         if (r_state == ST_IDLE) begin
            w_si_nxt = s_if.S_DATA[0];
         end else begin
            w_si_nxt   = (w_half_end && r_phase) ? r_shift[1] : r_si;
            w_sclk_nxt = w_half_end ? ~r_phase : r_sclk;
         end
      end
      w_le_nxt   = (w_state_nxt == ST_LATCH);
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      w_done_nxt = ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE))
                 || (w_accept && w_skip);
   end

   // Output registers keep SI/SCLK/LE glitch-free.
   always_ff @(posedge CLK_ATT or posedge RESET_ATT) begin
      if (RESET_ATT) begin
         r_si   <= 1'b0;
         r_sclk <= 1'b0;
         r_le   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_si   <= w_si_nxt;
         r_sclk <= w_sclk_nxt;
         r_le   <= w_le_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   // Shift register, SCLK phase divider, bit and settle counters.
   always_ff @(posedge CLK_ATT or posedge RESET_ATT) begin
      if (RESET_ATT) begin
         r_shift  <= '0;
         r_div    <= '0;
         r_phase  <= 1'b0;
         r_bit    <= '0;
         r_settle <= '0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (w_accept) begin
                  r_shift  <= s_if.S_DATA;
                  r_div    <= '0;
                  r_phase  <= 1'b0;
                  r_bit    <= '0;
                  r_settle <= '0;
               end
            ST_SHIFT:
               if (w_half_end) begin
                  r_div   <= '0;
                  r_phase <= ~r_phase;
                  if (r_phase) begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            ST_LATCH: begin
               r_div    <= w_latch_end ? '0 : r_div + 1'b1;
               r_settle <= '0;
            end
            ST_SETTLE:
               r_settle <= r_settle + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
